// File: rtl/systolic_skew_feeder.sv
// Buffers a DIM x DIM operand tile and streams it into the array edge lanes with
// a diagonal skew (lane r runs r cycles behind lane 0), driving en_out and done.
module systolic_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DIM)-1:0]   wr_row,
  input  logic [DIM*BITS_AB-1:0]   wr_data,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   lane_out,
  output logic [DIM-1:0]           lane_vld,
  output logic                     en_out,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(DIM);
  localparam int TW = $clog2(2*DIM-1);
  localparam logic [TW-1:0]        LAST  = TW'(2*DIM-2);
  localparam logic [RW:0]          DIM_L = (RW+1)'(DIM);
  localparam logic signed [TW+1:0] DIM_S = (TW+2)'(DIM);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]             state_reg;
  logic [TW-1:0]          t_reg;
  logic [TW-1:0]          step;
  logic                   go;
  logic                   last;
  logic                   wr_ok;
  logic                   en_reg;
  logic                   done_reg;
  logic [DIM*BITS_AB-1:0] lane_reg;
  logic [DIM-1:0]         vld_reg;
  logic [DIM*BITS_AB-1:0] lane_next;
  logic [DIM-1:0]         vld_next;
  logic [BITS_AB-1:0]     tile [DIM][DIM];

  // A start on the final step restarts immediately so back-to-back streams have no gap.
  always_comb begin
    last = (state_reg == STREAM) && (t_reg == LAST);
    go   = 1'b0;
    step = '0;
    if (state_reg == IDLE) begin
      go = start;
    end else if (!last) begin
      go   = 1'b1;
      step = t_reg + TW'(1);
    end else begin
      go = start;
    end
  end

  assign wr_ok = (state_reg == IDLE) && !start && wr_en && ({1'b0, wr_row} < DIM_L);

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
      logic signed [TW+1:0] k;
      logic [RW-1:0]        kidx;
      assign k    = $signed({2'b00, step}) - $signed((TW+2)'(gi));
      assign kidx = k[RW-1:0];
      assign vld_next[gi] = !k[TW+1] && (k < DIM_S);
      assign lane_next[gi*BITS_AB +: BITS_AB] = vld_next[gi] ? tile[gi][kidx] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      lane_reg  <= '0;
      vld_reg   <= '0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last;
      if (go) begin
        state_reg <= STREAM;
        t_reg     <= step;
        lane_reg  <= lane_next;
        vld_reg   <= vld_next;
        en_reg    <= 1'b1;
      end else begin
        state_reg <= IDLE;
        t_reg     <= '0;
        lane_reg  <= '0;
        vld_reg   <= '0;
        en_reg    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          tile[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      for (int c = 0; c < DIM; c++) begin
        tile[wr_row][c] <= wr_data[c*BITS_AB +: BITS_AB];
      end
    end
  end

  assign lane_out = lane_reg;
  assign lane_vld = vld_reg;
  assign en_out   = en_reg;
  assign busy     = (state_reg == STREAM);
  assign done     = done_reg;

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder for the systolic MAC array. It buffers a DIM×DIM tile of signed operands, loaded one row per write. On command it streams the tile into the array's edge lanes with diagonal skew, so lane r is delayed r cycles behind lane 0. It also drives the array's shared `en` strobe for the whole stream and raises `done` when the tile has fully entered the array.

## Interface
- `BITS_AB`, default 8: width of one signed operand.
- `DIM`, default 8: array dimension (lanes, rows, elements per row); must be ≥2.
- `clk` input 1: single clock; everything updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: write one row into the tile buffer.
- `wr_row` input $clog2(DIM): row index to write.
- `wr_data` input DIM*BITS_AB: row contents; element k at bits [k*BITS_AB +: BITS_AB].
- `start` input 1: begin streaming the buffered tile.
- `lane_out` output DIM*BITS_AB: registered lane operands; lane r at bits [r*BITS_AB +: BITS_AB]; feeds array `Ain` of row r.
- `lane_vld` output DIM: registered; bit r high when lane r carries a real element.
- `en_out` output 1: registered array enable, high for every stream step.
- `busy` output 1: high while in STREAM.
- `done` output 1: registered one-cycle pulse after the last step.

## Operation
- Tile buffer: DIM rows × DIM elements × BITS_AB bits; A[r][k] = element k of row r. Contents persist across streams until overwritten.
- Operands are pass-through. No arithmetic; signed bit patterns are reproduced exactly.
- FSM states:
  - IDLE to STREAM on `start`.
  - STREAM to IDLE after step 2*DIM-2.
- Step counter `t`, range 0..2*DIM-2, is valid in STREAM only.
- Step t, per lane r:
  - Let k = t-r. If 0 ≤ k < DIM, then `lane_out[r]` = A[r][k] and `lane_vld[r]` = 1.
  - Otherwise `lane_out[r]` = 0 and `lane_vld[r]` = 0.
- `en_out` = 1 on every step; it is 0 in IDLE.
- Writes:
  - Accepted only in IDLE with `start` low.
  - A write with `wr_row` ≥ DIM is ignored.
  - `wr_en` during STREAM is ignored, and the buffer is unchanged.
- `start` during STREAM is ignored; there is no queueing.
- `start` and `wr_en` in the same IDLE cycle: `start` wins, the write is dropped, and the stream uses the pre-edge buffer.
- Reset:
  - All outputs are 0, the buffer is zeroed, and the FSM is in IDLE.
  - Reset asserted mid-stream clears outputs immediately, with no `done`. After release the FSM is in IDLE and the buffer is zero.

## Timing
- Edge E0: first rising edge with `start` high in IDLE. From E0 the outputs show step 0 (`busy`=1, `en_out`=1, `lane_out[0]`=A[0][0]).
- Edge E0+t, for t ≤ 2*DIM-2: outputs show step t.
- Edge E0+2*DIM-1:
  - State returns to IDLE; `busy`, `en_out`, `lane_vld` and `lane_out` go to 0.
  - `done`=1 for exactly this one cycle.
- Stream length is 2*DIM-1 cycles of `en_out`.
- A new `start` is accepted at the earliest on edge E0+2*DIM-1 itself, the cycle `done` is high. In that case `done` still pulses and step 0 of the new stream appears with no gap.
- A write is visible to any stream started on a later edge.

## Test plan
(DIM=4, BITS_AB=8)
- **Reset state:** `rst_n`=0 asynchronously mid-cycle -> all outputs 0 without waiting for a clock edge. After release, `start` streams zeros with `lane_vld` still following the diagonal pattern.
- **Basic skew:** write rows r=0..3 with A[r][k]=16*r+k, then pulse `start`.
  - Step 0: `lane_out`={0,0,0,0x00}, vld=0001.
  - Step 3: lanes 3..0 = {0x30,0x21,0x12,0x03}, vld=1111.
  - Step 6: lane 3 = 0x33, vld=1000.
  - `done` at E0+7; `en_out` high exactly 7 cycles.
- **Signed pass-through:** A[2][1]=8'h80, A[1][0]=8'hFF -> exact bit patterns appear: lane 1 = 8'hFF at step 1, lane 2 = 8'h80 at step 3.
- **Illegal writes:**
  - `wr_en` during STREAM with row 0 = 8'h55 -> ignored; the next stream shows the original row 0.
  - `wr_row` ≥ DIM cannot occur at DIM=4. Rerun at DIM=3 with `wr_row`=3 -> no row changes.
- **Collisions:**
  - `start`+`wr_en` in the same idle cycle -> the write is dropped.
  - `start` pulsed mid-stream -> ignored, `done` once.
  - `start` on the `done` cycle -> back-to-back streams, 14 contiguous `en_out` cycles.
- **Reset mid-stream:** assert `rst_n`=0 at step 3 -> outputs 0, no `done`. After release the FSM is IDLE and a new stream outputs all-zero data.
